// File: rtl/argon_alu_seq.sv
// argon_alu_seq: sequences one ALU operation per request.
// For each request it loads the operands and opcode into the ALU over its bus,
// lets the ALU execute, and reads back the result and the flags. The result and
// flags are then returned on a valid/ready response channel.
// Optional feature macro: ARGON_ALUSEQ_FLAGS_LOAD_EN adds a flags preload step
// (LD_F) and the i_req_flags / i_req_load_f ports.

package argon_pkg;
    localparam int WORDSIZE = 16;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_ADC = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_SBC = 4'h3;
    localparam logic [3:0] ALU_AND = 4'h4;
    localparam logic [3:0] ALU_OR  = 4'h5;
    localparam logic [3:0] ALU_XOR = 4'h6;
    localparam logic [3:0] ALU_INC = 4'h8;
    localparam logic [3:0] ALU_DEC = 4'h9;
    localparam logic [3:0] ALU_CMP = 4'hA;

    localparam int F_CARRY = 0;
    localparam int F_ZERO  = 1;
endpackage

module argon_alu_seq
    import argon_pkg::*;
(
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [3:0]          i_req_op,
    input  logic [WORDSIZE-1:0] i_req_a,
    input  logic [WORDSIZE-1:0] i_req_b,
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
    input  logic [WORDSIZE-1:0] i_req_flags,
    input  logic                i_req_load_f,
`endif
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [WORDSIZE-1:0] o_rsp_y,
    output logic [WORDSIZE-1:0] o_rsp_flags,
    output logic [WORDSIZE-1:0] o_bus_data,
    output logic                o_bus_valid,
    input  logic [WORDSIZE-1:0] i_bus_data,
    output logic                o_latchA,
    output logic                o_latchB,
    output logic                o_latchF,
    output logic                o_latchOp,
    output logic                o_outputY,
    output logic                o_outputF,
    output logic                o_busy
);

    typedef enum logic [2:0] {
        IDLE,
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
        LD_F,
`endif
        LD_A,
        LD_B,
        LD_OP,
        EXEC,
        RD_F,
        RESP
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [3:0]          op_q;
    logic [WORDSIZE-1:0] a_q;
    logic [WORDSIZE-1:0] b_q;
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
    logic [WORDSIZE-1:0] flags_q;
    logic                load_f_q;
`endif
    logic [WORDSIZE-1:0] rsp_y_q;
    logic [WORDSIZE-1:0] rsp_flags_q;

    logic                accept;
    logic                is_unary;

    assign accept   = (state == IDLE) && i_req_valid;
    assign is_unary = (op_q == ALU_INC) || (op_q == ALU_DEC);

    assign o_rsp_y     = rsp_y_q;
    assign o_rsp_flags = rsp_flags_q;

    // State register; reset aborts any operation in progress immediately.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are captured only on the IDLE handshake, so the requester may change them freely afterwards.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
            flags_q  <= '0;
            load_f_q <= 1'b0;
`endif
        end else if (accept) begin
            op_q     <= i_req_op;
            a_q      <= i_req_a;
            b_q      <= i_req_b;
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
            flags_q  <= i_req_flags;
            load_f_q <= i_req_load_f;
`endif
        end
    end

    // Result is read while the ALU drives Y during EXEC; flags are read one cycle later, after the ALU has updated them.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            if (state == EXEC) begin
                rsp_y_q <= i_bus_data;
            end
            if (state == RD_F) begin
                rsp_flags_q <= i_bus_data;
            end
        end
    end

    // Next-state and ALU control decode; each working state raises exactly one strobe.
    always_comb begin
        state_next  = state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_bus_valid = 1'b0;
        o_bus_data  = '0;
        o_latchA    = 1'b0;
        o_latchB    = 1'b0;
        o_latchF    = 1'b0;
        o_latchOp   = 1'b0;
        o_outputY   = 1'b0;
        o_outputF   = 1'b0;
        o_busy      = 1'b1;

        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_req_valid) begin
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
                    state_next = i_req_load_f ? LD_F : LD_A;
`else
                    state_next = LD_A;
`endif
                end
            end
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
            LD_F: begin
                o_bus_valid = 1'b1;
                o_latchF    = 1'b1;
                o_bus_data  = flags_q;
                state_next  = LD_A;
            end
`endif
            LD_A: begin
                o_bus_valid = 1'b1;
                o_latchA    = 1'b1;
                o_bus_data  = a_q;
                state_next  = is_unary ? LD_OP : LD_B;
            end
            LD_B: begin
                o_bus_valid = 1'b1;
                o_latchB    = 1'b1;
                o_bus_data  = b_q;
                state_next  = LD_OP;
            end
            LD_OP: begin
                o_bus_valid = 1'b1;
                o_latchOp   = 1'b1;
                o_bus_data  = {12'h000, op_q};
                state_next  = EXEC;
            end
            EXEC: begin
                o_outputY  = 1'b1;
                state_next = RD_F;
            end
            RD_F: begin
                o_outputF  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_argon_alu_seq.sv
// Testbench for argon_alu_seq. A small behavioural ALU sits on the bus side:
// it latches bus data on the strobes, drives Y combinationally while outputY
// is high, updates its flags at the end of that cycle and drives the flags
// while outputF is high. Build with ARGON_ALUSEQ_FLAGS_LOAD_EN to exercise preload.

module tb_argon_alu_seq;
    import argon_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
    logic [15:0] req_flags = '0;
    logic        req_load_f = 1'b0;
`endif
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_y;
    logic [15:0] rsp_flags;
    logic [15:0] bus_data_out;
    logic        bus_valid;
    logic [15:0] bus_data_in;
    logic        latch_a, latch_b, latch_f, latch_op, output_y, output_f;
    logic        busy;

    int check_count = 0;
    int pass_count  = 0;

    argon_alu_seq dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
        .i_req_flags  (req_flags),
        .i_req_load_f (req_load_f),
`endif
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_y      (rsp_y),
        .o_rsp_flags  (rsp_flags),
        .o_bus_data   (bus_data_out),
        .o_bus_valid  (bus_valid),
        .i_bus_data   (bus_data_in),
        .o_latchA     (latch_a),
        .o_latchB     (latch_b),
        .o_latchF     (latch_f),
        .o_latchOp    (latch_op),
        .o_outputY    (output_y),
        .o_outputF    (output_f),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {new_flags, y}; Y uses the flags held before execution.
    function automatic logic [31:0] aluEval(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] f);
        logic [16:0] s;
        logic [15:0] y;
        logic [15:0] nf;
        s  = '0;
        nf = f;
        case (op)
            ALU_ADD: s = {1'b0, a} + {1'b0, b};
            ALU_ADC: s = {1'b0, a} + {1'b0, b} + {16'h0, f[F_CARRY]};
            ALU_SUB: s = {1'b0, a} - {1'b0, b};
            ALU_SBC: s = {1'b0, a} - {1'b0, b} - {16'h0, f[F_CARRY]};
            ALU_INC: s = {1'b0, a} + 17'd1;
            ALU_DEC: s = {1'b0, a} - 17'd1;
            ALU_AND: s = {1'b0, a & b};
            ALU_OR:  s = {1'b0, a | b};
            ALU_XOR: s = {1'b0, a ^ b};
            default: s = '0;
        endcase
        y = s[15:0];
        case (op)
            ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_INC, ALU_DEC: begin
                nf[F_CARRY] = s[16];
                nf[F_ZERO]  = (y == 16'h0);
            end
            ALU_AND, ALU_OR, ALU_XOR: nf[F_ZERO] = (y == 16'h0);
            ALU_CMP: begin
                nf[F_CARRY] = (a < b);
                nf[F_ZERO]  = (a == b);
            end
            default: nf = f;
        endcase
        return {nf, y};
    endfunction

    logic [15:0] alu_a = '0, alu_b = '0, alu_f = '0;
    logic [3:0]  alu_op = '0;
    logic [31:0] alu_res;

    // Model ALU evaluation from its latched registers.
    always_comb alu_res = aluEval(alu_op, alu_a, alu_b, alu_f);

    // Model ALU registers: bus latches and the flag update at the execute edge.
    always @(posedge clk) begin
        if (bus_valid && latch_a)  alu_a  <= bus_data_out;
        if (bus_valid && latch_b)  alu_b  <= bus_data_out;
        if (bus_valid && latch_f)  alu_f  <= bus_data_out;
        if (bus_valid && latch_op) alu_op <= bus_data_out[3:0];
        if (output_y)              alu_f  <= alu_res[31:16];
    end

    assign bus_data_in = output_y ? alu_res[15:0] : (output_f ? alu_f : 16'h0000);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    // Runs one request from handshake to response acceptance, recording timing and protocol violations.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic lf, input logic [15:0] fl, input int hold,
                                 output logic [15:0] y, output logic [15:0] f, output int lat,
                                 output int viol, output logic saw_b, output int cyc_f,
                                 output int cyc_a, output logic ready_after);
        int n_strobe;
        y = '0; f = '0; lat = 0; viol = 0; saw_b = 1'b0; cyc_f = -1; cyc_a = -1;
        ready_after = 1'b0;
        @(negedge clk);
        if (req_ready !== 1'b1) viol++;
        req_valid = 1'b1;
        req_op = op; req_a = a; req_b = b;
`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
        req_load_f = lf; req_flags = fl;
`else
        if (lf) viol++;
        if (fl != 16'h0) viol++;
`endif
        @(posedge clk);
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0;
                req_op = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
            end
            if (rsp_valid === 1'b1) break;
            n_strobe = int'(latch_a) + int'(latch_b) + int'(latch_f) + int'(latch_op)
                     + int'(output_y) + int'(output_f);
            if (n_strobe != 1) viol++;
            if (busy !== 1'b1 || req_ready !== 1'b0) viol++;
            if (bus_valid !== (latch_a | latch_b | latch_f | latch_op)) viol++;
            if (!bus_valid && bus_data_out !== 16'h0) viol++;
            if (latch_b) saw_b = 1'b1;
            if (latch_f && cyc_f < 0) cyc_f = lat;
            if (latch_a && cyc_a < 0) cyc_a = lat;
        end
        if (rsp_valid !== 1'b1) begin
            $display("[TB] FAIL response_timeout: got no valid expected valid within 30 cycles");
            check_count++;
            return;
        end
        y = rsp_y;
        f = rsp_flags;
        for (int i = 0; i < hold; i++) begin
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_y !== y || rsp_flags !== f) viol++;
            @(negedge clk);
        end
        if (rsp_valid !== 1'b1 || rsp_y !== y || rsp_flags !== f) viol++;
        if (latch_a | latch_b | latch_f | latch_op | output_y | output_f | bus_valid) viol++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ready_after = req_ready;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) viol++;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_y;
        logic [15:0] exp_f;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    logic [15:0] y, f;
    int          lat, viol, cyc_f, cyc_a;
    logic        saw_b, ready_after;

    initial begin
        // Hand-computed vectors; the order matters because ADC/SBC consume the carry left by the previous op.
        vecs[0]  = '{"add_3_4",     ALU_ADD, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 6};
        vecs[1]  = '{"add_wrap",    ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0003, 6};
        vecs[2]  = '{"adc_chain",   ALU_ADC, 16'h0001, 16'h0001, 16'h0003, 16'h0000, 6};
        vecs[3]  = '{"inc_00ff",    ALU_INC, 16'h00FF, 16'hAAAA, 16'h0100, 16'h0000, 5};
        vecs[4]  = '{"dec_0001",    ALU_DEC, 16'h0001, 16'h5555, 16'h0000, 16'h0002, 5};
        vecs[5]  = '{"sub_5_3",     ALU_SUB, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 6};
        vecs[6]  = '{"xor",         ALU_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 16'h0000, 6};
        vecs[7]  = '{"cmp_eq",      ALU_CMP, 16'h0005, 16'h0005, 16'h0000, 16'h0002, 6};
        vecs[8]  = '{"reserved_f",  4'hF,    16'h1234, 16'h5678, 16'h0000, 16'h0002, 6};
        vecs[9]  = '{"sub_borrow",  ALU_SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'h0001, 6};
        vecs[10] = '{"sbc_borrow",  ALU_SBC, 16'h0005, 16'h0001, 16'h0003, 16'h0000, 6};

        #2;
        checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("reset_busy_valid", {30'h0, busy, rsp_valid}, 32'h0);
        checkOutput("reset_strobes", {25'h0, bus_valid, latch_a, latch_b, latch_f, latch_op, output_y, output_f}, 32'h0);
        checkOutput("reset_rsp_data", {rsp_y, rsp_flags}, 32'h0);
        checkOutput("reset_bus_data", {16'h0, bus_data_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 16'h0, 0,
                          y, f, lat, viol, saw_b, cyc_f, cyc_a, ready_after);
            checkOutput({vecs[i].name, "_y"}, {16'h0, y}, {16'h0, vecs[i].exp_y});
            checkOutput({vecs[i].name, "_flags"}, {16'h0, f}, {16'h0, vecs[i].exp_f});
            checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
            checkOutput({vecs[i].name, "_protocol"}, viol, 0);
            checkOutput({vecs[i].name, "_latchB_seen"}, {31'h0, saw_b}, {31'h0, (vecs[i].exp_lat == 6)});
            checkOutput({vecs[i].name, "_ready_after"}, {31'h0, ready_after}, 32'h1);
        end

        // Backpressure: response held 10 cycles before acceptance.
        applyStimulus(ALU_ADD, 16'h1111, 16'h2222, 1'b0, 16'h0, 10,
                      y, f, lat, viol, saw_b, cyc_f, cyc_a, ready_after);
        checkOutput("stall_y", {16'h0, y}, 32'h3333);
        checkOutput("stall_flags", {16'h0, f}, 32'h0);
        checkOutput("stall_stable", viol, 0);
        checkOutput("stall_ready_after", {31'h0, ready_after}, 32'h1);

        // Reset pulse during LD_B aborts the operation in the same cycle.
        @(negedge clk);
        req_valid = 1'b1; req_op = ALU_ADD; req_a = 16'h0101; req_b = 16'h0202;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_ldb", {31'h0, latch_b}, 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_idle", {30'h0, req_ready, busy}, 32'h2);
        checkOutput("abort_strobes", {25'h0, bus_valid, latch_a, latch_b, latch_f, latch_op, output_y, output_f}, 32'h0);
        checkOutput("abort_rsp_cleared", {rsp_y, rsp_flags}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) viol++;
        end
        checkOutput("abort_no_response", viol, 0);
        applyStimulus(ALU_XOR, 16'hF0F0, 16'h0FF0, 1'b0, 16'h0, 0,
                      y, f, lat, viol, saw_b, cyc_f, cyc_a, ready_after);
        checkOutput("post_abort_xor_y", {16'h0, y}, 32'hFF00);
        checkOutput("post_abort_latency", lat, 6);
        checkOutput("post_abort_protocol", viol, 0);

`ifdef ARGON_ALUSEQ_FLAGS_LOAD_EN
        // Clear the carry, then preload it through LD_F so ADC sees carry=1.
        applyStimulus(ALU_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0, 0,
                      y, f, lat, viol, saw_b, cyc_f, cyc_a, ready_after);
        checkOutput("preload_setup_flags", {16'h0, f}, 32'h0);
        applyStimulus(ALU_ADC, 16'h0001, 16'h0001, 1'b1, 16'h0001, 0,
                      y, f, lat, viol, saw_b, cyc_f, cyc_a, ready_after);
        checkOutput("preload_adc_y", {16'h0, y}, 32'h0003);
        checkOutput("preload_latency", lat, 7);
        checkOutput("preload_latchF_cycle", cyc_f, 1);
        checkOutput("preload_latchA_cycle", cyc_a, 2);
        checkOutput("preload_protocol", viol, 0);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/argon_alu_seq.md
# argon_alu_seq

ALU sequencer. Accepts one ALU operation per request (opcode plus operands) over a valid/ready handshake. Drives the ALU's bus-write strobes and latch/output controls to load operands, execute, and read back result and flags. Returns both to the requester over a valid/ready response channel. Sits between the CPU control unit and the ALU, and is the sole master of the ALU's control wires and bus input.

## Interface
- No parameters; word width is `WORDSIZE` (16) from `argon_pkg`.
- `i_Clk` in 1: clock, rising edge.
- `i_Reset` in 1: asynchronous reset, active-high.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: sequencer can accept a request (high only in IDLE).
- `i_req_op` in 4: ALU opcode (`argon_pkg` ALU_* encoding).
- `i_req_a` in 16: operand A.
- `i_req_b` in 16: operand B (ignored for ALU_INC and ALU_DEC).
- `i_req_flags` in 16: flags to preload (only with `ARGON_ALUSEQ_FLAGS_LOAD_EN`).
- `i_req_load_f` in 1: preload flags before the op (only with the macro).
- `o_rsp_valid` out 1: result available.
- `i_rsp_ready` in 1: requester accepts result.
- `o_rsp_y` out 16: captured ALU result.
- `o_rsp_flags` out 16: captured ALU flags after execution.
- `o_bus_data` out 16: data to ALU `bus_if.i_data`.
- `o_bus_valid` out 1: to ALU `bus_if.i_valid`.
- `i_bus_data` in 16: from ALU `bus_if.o_data`.
- `o_latchA`, `o_latchB`, `o_latchF`, `o_latchOp` out 1 each: ALU latch strobes.
- `o_outputY`, `o_outputF` out 1 each: ALU output selects.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LD_F, LD_A, LD_B, LD_OP, EXEC, RD_F, RESP.
- IDLE: `o_req_ready`=1. On `i_req_valid`, register op/A/B (and flags/load_f), then go to LD_F if load_f else LD_A.
- LD_F: `o_bus_valid`=1, `o_latchF`=1, `o_bus_data`=flags, then LD_A.
- LD_A: `o_bus_valid`=1, `o_latchA`=1, data=A. Next is LD_OP if op is ALU_INC or ALU_DEC, else LD_B.
- LD_B: `o_bus_valid`=1, `o_latchB`=1, data=B, then LD_OP.
- LD_OP: `o_bus_valid`=1, `o_latchOp`=1, data=`{12'h000, op}`, then EXEC.
- EXEC: `o_bus_valid`=0 (ALU executes at this edge), `o_outputY`=1. Capture `i_bus_data` into `o_rsp_y` at the end of the cycle. This is the pre-update result and uses the carry in effect before execution. Then RD_F.
- RD_F: `o_outputF`=1. Capture `i_bus_data` into `o_rsp_flags` (post-execution flags). Then RESP.
- RESP: `o_rsp_valid`=1. `o_rsp_y`/`o_rsp_flags` are held stable until `i_rsp_ready`; then IDLE.
- Exactly one latch or output strobe is active per cycle. All strobes are 0 in IDLE and RESP.
- `o_bus_data`=0 whenever `o_bus_valid`=0.
- ALU_CMP and reserved opcodes are sequenced identically (ALU returns Y=0; CMP updates compare flags; reserved leaves flags unchanged).
- Operand/opcode registers load only on the IDLE handshake. Request inputs are ignored outside IDLE.

## Timing
- Reset (async): state=IDLE. All outputs 0 except `o_req_ready`=1. `o_rsp_y`=0, `o_rsp_flags`=0.
- Handshake in cycle 0 → LD_A cycle 1 → LD_B cycle 2 → LD_OP 3 → EXEC 4 → RD_F 5 → `o_rsp_valid` in cycle 6.
- Unary ops (INC/DEC) are one cycle shorter (valid in cycle 5). Flag preload adds one cycle.
- No overlap: `o_req_ready` rises the cycle after the response handshake. Peak throughput is one op per 7 cycles for binary ops without preload.
- `o_rsp_valid` is held with stable data under backpressure for any number of cycles.
- Reset asserted in any state aborts immediately. No response is produced, and the ALU may hold partial operands.

## Configuration
- `ARGON_ALUSEQ_FLAGS_LOAD_EN` defined: `i_req_flags`/`i_req_load_f` ports exist, and the LD_F state is reachable.
- Macro undefined: ports absent, LD_F removed, and `o_latchF` tied 0. The op uses whatever flags the ALU holds from the previous operation, so ADC/SBC chain naturally.

## Test plan
- ALU_ADD A=0x0003 B=0x0004 → `o_rsp_valid` in cycle 6, Y=0x0007, F_CARRY=0, F_ZERO=0.
- ALU_ADD A=0xFFFF B=0x0001 → Y=0x0000, F_CARRY=1, F_ZERO=1; then ALU_ADC A=0x0001 B=0x0001 → Y=0x0003, F_CARRY=0.
- ALU_INC A=0x00FF → `o_latchB` never asserted, valid in cycle 5, Y=0x0100.
- Backpressure: hold `i_rsp_ready`=0 for 10 cycles after valid → Y/flags stable, `o_req_ready`=0 throughout; accept → `o_req_ready`=1 the next cycle.
- `i_Reset` pulsed during LD_B → same-cycle return to IDLE, all strobes 0, no `o_rsp_valid`. A following ALU_XOR 0xF0F0^0x0FF0 → Y=0xFF00.
- With macro: ALU_ADC A=0x0001 B=0x0001, load_f=1, flags=0x0001 (F_CARRY) → `o_latchF` pulses one cycle before `o_latchA`, Y=0x0003.
